// File: rtl/wb_b3_pkg.sv
// Shared Wishbone B3 encodings (cycle type, burst type) and burst-master FSM states.
package wb_b3_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUS    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/wb_b3_burst_adr_next.sv
// Next beat address for a Wishbone burst: +4 linear, or +4 wrapping inside a 4/8/16-beat block.
// Purely combinational, zero latency; no flow control.
module wb_b3_burst_adr_next
    import wb_b3_pkg::*;
#(
    parameter int aw = 32
) (
    input  logic [aw-1:0] adr,
    input  logic [1:0]    bte,
    output logic [aw-1:0] adr_nxt
);

    logic [aw-1:0] inc;
    logic [aw-1:0] mask;

    // Bits selected by mask take the incremented value, the rest hold.
    always_comb begin
        inc  = adr + aw'(4);
        mask = '1;
        case (bte)
            BTE_WRAP4:  mask = aw'(32'h0000_000C);
            BTE_WRAP8:  mask = aw'(32'h0000_001C);
            BTE_WRAP16: mask = aw'(32'h0000_003C);
            default:    mask = '1;
        endcase
        adr_nxt = (adr & ~mask) | (inc & mask);
    end

endmodule

// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 burst master: one command becomes a classic or incrementing burst; stb from the cycle after accept.
// Slave stalls by withholding ack (watchdog aborts); cmd_ready low until the burst ends.
module wb_b3_burst_master
    import wb_b3_pkg::*;
#(
    parameter int dw             = 32,
    parameter int aw             = 32,
    parameter int timeout_cycles = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [aw-1:0] cmd_adr_i,
    input  logic [3:0]    cmd_len_i,
    input  logic [1:0]    cmd_bte_i,
    input  logic [3:0]    cmd_sel_i,
    input  logic [dw-1:0] wr_dat_i,
    output logic          wr_next_o,
    output logic [dw-1:0] rd_dat_o,
    output logic          rd_valid_o,
    output logic          done_o,
    output logic          err_o,
    output logic [aw-1:0] wb_adr_o,
    output logic [dw-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic [2:0]    wb_cti_o,
    output logic [1:0]    wb_bte_o,
    input  logic [dw-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i
);

    localparam int TW = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((timeout_cycles > 0) ? timeout_cycles - 1 : 0);

    state_t        state_q, state_d;
    logic          we_q;
    logic          classic_q;
    logic [1:0]    bte_q;
    logic [3:0]    sel_q;
    logic [3:0]    cnt_q;
    logic [aw-1:0] adr_q;
    logic [aw-1:0] adr_nxt;
    logic [TW-1:0] wait_q;

    logic in_bus;
    logic accept;
    logic beat_ok;
    logic last_beat;
    logic timeout_hit;
    logic abort;

    assign in_bus      = (state_q == ST_BUS);
    assign accept      = cmd_valid_i && (state_q == ST_IDLE);
    // An error or retry wins over an ack presented in the same cycle.
    assign beat_ok     = in_bus && wb_ack_i && !wb_err_i && !wb_rty_i;
    assign last_beat   = beat_ok && (cnt_q == 4'd0);
    assign timeout_hit = (timeout_cycles != 0) && in_bus && !wb_ack_i && (wait_q == TO_LAST);
    assign abort       = in_bus && (wb_err_i || wb_rty_i || timeout_hit);

    wb_b3_burst_adr_next #(.aw(aw)) u_adr_next (
        .adr     (adr_q),
        .bte     (bte_q),
        .adr_nxt (adr_nxt)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        done_o      = 1'b0;
        wb_cti_o    = CTI_CLASSIC;
        wb_bte_o    = BTE_LINEAR;
        case (state_q)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) state_d = ST_BUS;
            end
            ST_BUS: begin
                if (!classic_q) begin
                    wb_cti_o = (cnt_q == 4'd0) ? CTI_EOB : CTI_INCR;
                    wb_bte_o = bte_q;
                end
                if (abort)          state_d = ST_IDLE;
                else if (last_beat) state_d = ST_FINISH;
            end
            ST_FINISH: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign wb_cyc_o  = in_bus;
    assign wb_stb_o  = in_bus;
    assign wb_we_o   = in_bus && we_q;
    assign wb_sel_o  = in_bus ? sel_q : 4'd0;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = wr_dat_i;
    assign wr_next_o = beat_ok && we_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            we_q       <= 1'b0;
            classic_q  <= 1'b1;
            bte_q      <= BTE_LINEAR;
            sel_q      <= 4'd0;
            cnt_q      <= 4'd0;
            adr_q      <= '0;
            wait_q     <= '0;
            rd_dat_o   <= '0;
            rd_valid_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            rd_valid_o <= beat_ok && !we_q;
            err_o      <= abort;
            if (beat_ok && !we_q) rd_dat_o <= wb_dat_i;

            if (accept) begin
                we_q      <= cmd_we_i;
                classic_q <= (cmd_len_i == 4'd0);
                bte_q     <= cmd_bte_i;
                sel_q     <= cmd_sel_i;
                cnt_q     <= cmd_len_i;
                adr_q     <= cmd_adr_i & ~aw'(3);
                wait_q    <= '0;
            end else if (beat_ok) begin
                adr_q  <= adr_nxt;
                cnt_q  <= cnt_q - 4'd1;
                wait_q <= '0;
            end else if (in_bus) begin
                wait_q <= wait_q + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_b3_burst_master.sv
// Bench for wb_b3_burst_master: table of burst commands against a small Wishbone slave memory,
// plus hand-written timeout and mid-burst reset sequences.
module tb_wb_b3_burst_master;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [31:0] cmd_adr_i;
    logic [3:0]  cmd_len_i;
    logic [1:0]  cmd_bte_i;
    logic [3:0]  cmd_sel_i;
    logic [31:0] wr_dat_i;
    logic        wr_next_o;
    logic [31:0] rd_dat_o;
    logic        rd_valid_o, done_o, err_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i, wb_err_i, wb_rty_i;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_b3_burst_master #(.dw(32), .aw(32), .timeout_cycles(8)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i), .cmd_bte_i(cmd_bte_i), .cmd_sel_i(cmd_sel_i),
        .wr_dat_i(wr_dat_i), .wr_next_o(wr_next_o), .rd_dat_o(rd_dat_o), .rd_valid_o(rd_valid_o),
        .done_o(done_o), .err_o(err_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    // ---------------- slave memory ----------------
    logic [31:0] mem [0:255];
    logic        silent, ws_en, ws_phase, rty_mode, ackerr, mem_clear, mon_clr;
    int          err_beat, beat_no, wr_idx;
    logic [31:0] wr_seed;
    logic        resp, is_err;

    always_comb begin
        resp     = wb_cyc_o && wb_stb_o && !silent && (!ws_en || ws_phase);
        is_err   = (beat_no == err_beat);
        wb_ack_i = resp && (!is_err || ackerr);
        wb_err_i = resp && is_err && !rty_mode;
        wb_rty_i = resp && is_err && rty_mode;
        wb_dat_i = mem[wb_adr_o[9:2]];
        wr_dat_i = wr_seed + wr_idx * 32'h111;
    end

    always @(posedge wb_clk_i) begin
        if (mem_clear) for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5_0000 + i;
        else if (wb_ack_i && wb_we_o) mem[wb_adr_o[9:2]] <= wb_dat_o;
        if (mon_clr) wr_idx <= 0;
        else if (wr_next_o) wr_idx <= wr_idx + 1;
        if (!(wb_cyc_o && wb_stb_o)) begin
            beat_no  <= 0;
            ws_phase <= 1'b0;
        end else begin
            ws_phase <= ~ws_phase;
            if (wb_ack_i) beat_no <= beat_no + 1;
        end
    end

    // ---------------- monitor ----------------
    int          cyc_n = 0;
    int          n_beats, n_rdv, n_wrn, n_done, n_err, first_stb, last_bus, end_cyc, rdy_in_bus;
    logic [31:0] log_adr [0:31];
    logic [2:0]  log_cti [0:31];
    logic [1:0]  log_bte [0:31];
    logic [3:0]  log_sel [0:31];
    logic [31:0] rd_log  [0:31];

    always @(negedge wb_clk_i) begin
        if (mon_clr) begin
            n_beats = 0; n_rdv = 0; n_wrn = 0; n_done = 0; n_err = 0;
            first_stb = -1; last_bus = -1; end_cyc = -1; rdy_in_bus = 0;
        end else begin
            if (wb_cyc_o) begin
                last_bus = cyc_n;
                if (first_stb < 0 && wb_stb_o) first_stb = cyc_n;
                if (cmd_ready_o) rdy_in_bus++;
            end
            if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i && !wb_rty_i && n_beats < 32) begin
                log_adr[n_beats] = wb_adr_o;
                log_cti[n_beats] = wb_cti_o;
                log_bte[n_beats] = wb_bte_o;
                log_sel[n_beats] = wb_sel_o;
                n_beats++;
            end
            if (rd_valid_o && n_rdv < 32) begin
                rd_log[n_rdv] = rd_dat_o;
                n_rdv++;
            end
            if (wr_next_o) n_wrn++;
            if (done_o) begin n_done++; end_cyc = cyc_n; end
            if (err_o)  begin n_err++;  end_cyc = cyc_n; end
        end
        cyc_n++;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] shadow [0:255];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mdl_next(input logic [31:0] a, input logic [1:0] b);
        int unsigned bs;
        bs = (b == 2'd0) ? 0 : (8 << b);
        if (bs == 0) return a + 32'd4;
        return (a - (a % bs)) + ((a % bs + 4) % bs);
    endfunction

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  len;
        logic [1:0]  bte;
        logic [3:0]  sel;
        logic        ws;
        logic        silent;
        logic        rty;
        logic        ackerr;
        int          err_beat;
        int          beats;
        int          exp_done;
        int          exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic issue(input vec_t v, input logic [31:0] seed);
        silent = v.silent; ws_en = v.ws; err_beat = v.err_beat;
        rty_mode = v.rty; ackerr = v.ackerr; wr_seed = seed;
        @(posedge wb_clk_i); #1;
        check("ready_before_cmd", cmd_ready_o, 1);
        mon_clr = 1'b1;
        cmd_we_i = v.we; cmd_adr_i = v.adr; cmd_len_i = v.len; cmd_bte_i = v.bte; cmd_sel_i = v.sel;
        cmd_valid_i = 1'b1;
        @(posedge wb_clk_i); #1;
        mon_clr = 1'b0;
        cmd_valid_i = 1'b0;
    endtask

    task automatic run_vec(input string tag, input vec_t v, input logic [31:0] seed);
        logic        ended;
        logic [31:0] a, ea;
        logic [2:0]  ecti;
        int          nb;
        issue(v, seed);
        ended = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (n_done + n_err > 0) begin ended = 1'b1; break; end
            @(posedge wb_clk_i); #1;
        end
        check({tag, "_completes"}, ended, 1);
        repeat (2) @(posedge wb_clk_i);
        #1;
        check({tag, "_beats"}, n_beats, v.beats);
        check({tag, "_rd_valid"}, n_rdv, v.we ? 0 : v.beats);
        check({tag, "_wr_next"}, n_wrn, v.we ? v.beats : 0);
        check({tag, "_done"}, n_done, v.exp_done);
        check({tag, "_err"}, n_err, v.exp_err);
        check({tag, "_end_after_cyc"}, end_cyc - last_bus, 1);
        check({tag, "_ready_in_bus"}, rdy_in_bus, 0);
        check({tag, "_idle_cyc"}, wb_cyc_o, 0);
        nb = (n_beats < 16) ? n_beats : 16;
        a = v.adr & ~32'd3;
        for (int k = 0; k < nb; k++) begin
            ecti = (v.len == 4'd0) ? 3'b000 : ((k == int'(v.len)) ? 3'b111 : 3'b010);
            check($sformatf("%s_adr%0d", tag, k), log_adr[k], a);
            check($sformatf("%s_cti%0d", tag, k), log_cti[k], ecti);
            check($sformatf("%s_bte%0d", tag, k), log_bte[k], (v.len == 4'd0) ? 2'b00 : v.bte);
            check($sformatf("%s_sel%0d", tag, k), log_sel[k], v.sel);
            if (!v.we && k < n_rdv)
                check($sformatf("%s_rdat%0d", tag, k), rd_log[k], shadow[a[9:2]]);
            if (v.we) begin
                ea = seed + k * 32'h111;
                check($sformatf("%s_mem%0d", tag, k), mem[a[9:2]], ea);
                shadow[a[9:2]] = ea;
            end
            a = mdl_next(a, v.bte);
        end
    endtask

    initial begin
        vec_t tv;
        vec_t sv;
        //            we adr     len bte sel  ws sil rty ae eb  beats done err
        vecs[0]  = '{0, 'h100,  0,  0, 'hF, 0, 0,  0,  0, -1, 1,  1, 0};
        vecs[1]  = '{1, 'h200,  3,  0, 'hF, 0, 0,  0,  0, -1, 4,  1, 0};
        vecs[2]  = '{0, 'h200,  3,  0, 'hF, 0, 0,  0,  0, -1, 4,  1, 0};
        vecs[3]  = '{0, 'h03C,  7,  2, 'hF, 0, 0,  0,  0, -1, 8,  1, 0};
        vecs[4]  = '{1, 'h048,  3,  1, 'h3, 1, 0,  0,  0, -1, 4,  1, 0};
        vecs[5]  = '{0, 'h040,  3,  0, 'hF, 1, 0,  0,  0, -1, 4,  1, 0};
        vecs[6]  = '{0, 'h300,  3,  0, 'hF, 0, 0,  0,  1,  2, 2,  0, 1};
        vecs[7]  = '{1, 'h010,  1,  0, 'hF, 0, 0,  1,  0,  0, 0,  0, 1};
        vecs[8]  = '{0, 'h074, 15,  3, 'hF, 1, 0,  0,  0, -1, 16, 1, 0};
        vecs[9]  = '{1, 'h0F0, 15,  0, 'hC, 0, 0,  0,  0, -1, 16, 1, 0};
        vecs[10] = '{0, 'h0F2,  0,  2, 'hF, 0, 0,  0,  0, -1, 1,  1, 0};
        vecs[11] = '{0, 'h104,  3,  1, 'hF, 0, 0,  0,  0, -1, 4,  1, 0};

        for (int i = 0; i < 256; i++) shadow[i] = 32'hA5A5_0000 + i;
        wb_rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0;
        cmd_len_i = '0; cmd_bte_i = '0; cmd_sel_i = '0;
        silent = 1'b0; ws_en = 1'b0; rty_mode = 1'b0; ackerr = 1'b0; err_beat = -1;
        wr_seed = '0; mem_clear = 1'b1; mon_clr = 1'b1;
        repeat (3) @(posedge wb_clk_i);
        #1;
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_stb", wb_stb_o, 0);
        check("rst_adr", wb_adr_o, 0);
        check("rst_cti", wb_cti_o, 0);
        check("rst_outs", {done_o, err_o, rd_valid_o, wr_next_o, wb_we_o}, 0);
        check("rst_rdat", rd_dat_o, 0);
        check("rst_ready", cmd_ready_o, 1);
        mem_clear = 1'b0;
        mon_clr = 1'b0;
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;

        for (int i = 0; i < 12; i++)
            run_vec($sformatf("v%0d", i), vecs[i], 32'hC0DE_0000 + (i << 12));

        // Silent slave: abort lands exactly timeout_cycles after stb rises.
        sv = '{0, 'h000, 3, 0, 'hF, 0, 1, 0, 0, -1, 0, 0, 1};
        run_vec("timeout", sv, 32'h0);
        check("timeout_delay", end_cyc - first_stb, 8);
        check("timeout_ready", cmd_ready_o, 1);

        // Reset in the middle of a 16-beat write with wait states.
        tv = '{1, 'h380, 15, 0, 'hF, 1, 0, 0, 0, -1, 16, 1, 0};
        issue(tv, 32'h5555_0000);
        repeat (5) @(posedge wb_clk_i);
        #2;
        check("pre_rst_cyc", wb_cyc_o, 1);
        wb_rst_ni = 1'b0;
        #1;
        check("mid_rst_cyc_stb", {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
        check("mid_rst_adr", wb_adr_o, 0);
        check("mid_rst_cti_bte", {wb_cti_o, wb_bte_o}, 0);
        check("mid_rst_sel", wb_sel_o, 0);
        check("mid_rst_pulses", {done_o, err_o, rd_valid_o, wr_next_o}, 0);
        check("mid_rst_rdat", rd_dat_o, 0);
        check("mid_rst_ready", cmd_ready_o, 1);
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        run_vec("post_rst", vecs[0], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/wb_b3_burst_master.md
WB_B3_BURST_MASTER -- requirements
Module: wb_b3_burst_master

Interface
REQ-001 SHALL have parameter dw, default 32: Wishbone data width; only 32 is supported.
REQ-002 SHALL have parameter aw, default 32: Wishbone address width.
REQ-003 SHALL have parameter timeout_cycles, default 255: maximum wait for ack/err per beat; 0 disables the watchdog.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports, in this order:
- wb_clk_i  in  1  clock.
- wb_rst_ni  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_we_i  in  1  1 = write burst, 0 = read burst.
- cmd_adr_i  in  aw  byte start address (bits [1:0] ignored).
- cmd_len_i  in  4  beats minus 1 (0..15).
- cmd_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- cmd_sel_i  in  4  byte select used for every beat.
- wr_dat_i  in  dw  current write word (show-ahead source).
- wr_next_o  out  1  pop strobe: current write word consumed.
- rd_dat_o  out  dw  read word.
- rd_valid_o  out  1  rd_dat_o valid, one cycle per beat.
- done_o  out  1  one-cycle pulse on successful completion.
- err_o  out  1  one-cycle pulse on abort (err, rty or timeout).
- wb_adr_o  out  aw  Wishbone address.
- wb_dat_o  out  dw  Wishbone write data.
- wb_sel_o  out  4  Wishbone byte select.
- wb_we_o  out  1  Wishbone write enable.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_cti_o  out  3  Wishbone cycle type identifier.
- wb_bte_o  out  2  Wishbone burst type extension.
- wb_dat_i  in  dw  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_err_i  in  1  Wishbone error.
- wb_rty_i  in  1  Wishbone retry.

Function
REQ-006 SHALL implement FSM states IDLE, BUS, FINISH; cmd_ready_o = (state == IDLE), combinational.
REQ-007 SHALL, on cmd_valid_i & cmd_ready_o at edge N, register all cmd_* fields and enter BUS, with wb_cyc_o = wb_stb_o = 1 from cycle N+1.
REQ-008 SHALL, for cmd_len_i = 0, issue a classic cycle: wb_cti_o = 000, wb_bte_o = 00.
REQ-009 SHALL, for cmd_len_i > 0, drive wb_cti_o = 010 and wb_bte_o = registered bte on every beat except the last, and wb_cti_o = 111 on the last beat.
REQ-010 SHALL hold wb_stb_o high continuously through BUS; a beat completes in any cycle with wb_ack_i high (zero wait states allowed).
REQ-011 SHALL, on each ack, advance wb_adr_o on the next edge: linear = +4 over full width; wrap4/8/16 = increment of adr[3:2]/[4:2]/[5:2] modulo 4/8/16, upper bits held.
REQ-012 SHALL keep a 4-bit remaining-beat counter, loaded with cmd_len_i and decremented per ack; the ack with counter = 0 is the last beat.
REQ-013 SHALL, for writes, drive wb_dat_o = wr_dat_i combinationally and pulse wr_next_o in each write-ack cycle.
REQ-014 SHALL, for reads, register wb_dat_i into rd_dat_o on each ack and assert rd_valid_o the following cycle.
REQ-015 SHALL, after the last ack, enter FINISH: cyc/stb/cti/bte deassert at that edge, done_o pulses for the FINISH cycle, then return to IDLE.
REQ-016 SHALL, on wb_err_i or wb_rty_i in BUS, drop cyc/stb at the next edge, pulse err_o once, issue no done_o, and return to IDLE; err has priority over a simultaneous ack.
REQ-017 SHALL count cycles without ack in BUS; reaching timeout_cycles aborts exactly as in REQ-016; the counter clears on every ack.
REQ-018 SHALL ignore cmd_valid_i outside IDLE.

Reset
REQ-019 SHALL, while wb_rst_ni = 0, force: state IDLE; wb_cyc_o, wb_stb_o, wb_we_o, wr_next_o, rd_valid_o, done_o, err_o = 0; wb_adr_o = 0; wb_cti_o = 000; wb_bte_o = 00; wb_sel_o = 0; rd_dat_o = 0.
REQ-020 SHALL, on reset mid-burst, abandon the burst immediately with no done_o/err_o; cmd_ready_o = 1 after deassertion.

Structure
REQ-021 SHALL place Wishbone CTI codes (000, 010, 111), BTE codes and FSM state encodings in a shared package, wb_b3_pkg.
REQ-022 SHALL contain one sub-module, wb_b3_burst_adr_next: combinational next-address function from address and bte.

Verification
REQ-023 SHALL check a classic read (adr 0x100, len 0) against ram_wb_b3: cti 000, one rd_valid_o with mem[0x40], done_o pulses.
REQ-024 SHALL check a linear 4-beat write at 0x200: addresses 0x200/204/208/20C, cti 010,010,010,111, four wr_next_o pulses, readback matches.
REQ-025 SHALL check a wrap8 read of 8 beats at 0x3C: addresses 0x3C,0x20,0x24,...,0x38; bte 10 on every beat.
REQ-026 SHALL check wb_err_i on beat 2 of a 4-beat read: cyc low next cycle, one err_o, two rd_valid_o, no done_o.
REQ-027 SHALL check a silent slave with timeout_cycles = 8: err_o pulses 8 cycles after stb is raised, then IDLE.
REQ-028 SHALL check wb_rst_ni asserted mid-burst: all outputs go to reset values immediately, and a new command is accepted after release.
